// File: rtl/xbar_cfg_loader_if.sv
// Config-stream handshake and crossbar select bundle for xbar_cfg_loader.
// The readback ports exist only when XBAR_CFG_READBACK_EN is defined.
interface xbar_cfg_loader_if #(
    parameter int unsigned CFG_W = 32,
    parameter int unsigned TOTAL = 180
);
    logic             io_start;
    logic             io_abort;
    logic [CFG_W-1:0] io_cfg_data;
    logic             io_cfg_valid;
    logic             io_cfg_ready;
    logic             io_busy;
    logic             io_done;
    logic             io_err;
    logic [5:0]       io_err_idx;
    logic [TOTAL-1:0] io_mux_configs;
`ifdef XBAR_CFG_READBACK_EN
    logic [2:0]       io_rd_idx;
    logic [CFG_W-1:0] io_rd_data;
`endif

    modport master (
`ifdef XBAR_CFG_READBACK_EN
        output io_rd_idx,
        input  io_rd_data,
`endif
        output io_start, io_abort, io_cfg_data, io_cfg_valid,
        input  io_cfg_ready, io_busy, io_done, io_err, io_err_idx, io_mux_configs
    );

    modport slave (
`ifdef XBAR_CFG_READBACK_EN
        input  io_rd_idx,
        output io_rd_data,
`endif
        input  io_start, io_abort, io_cfg_data, io_cfg_valid,
        output io_cfg_ready, io_busy, io_done, io_err, io_err_idx, io_mux_configs
    );
endinterface

// File: rtl/xbar_cfg_loader.sv
// Streams crossbar selects into a shadow, range-checks every field, and commits them atomically.
// Optional combinational readback of the active config: XBAR_CFG_READBACK_EN.
module xbar_cfg_loader #(
    parameter int unsigned N_IN  = 27,
    parameter int unsigned N_OUT = 36,
    parameter int unsigned SEL_W = 5,
    parameter int unsigned CFG_W = 32
) (
    input logic              clk,
    input logic              reset,
    xbar_cfg_loader_if.slave bus
);
    localparam int unsigned TOTAL   = N_OUT * SEL_W;
    localparam int unsigned N_WORDS = (TOTAL + CFG_W - 1) / CFG_W;
    localparam int unsigned PAD     = N_WORDS * CFG_W;
    localparam int unsigned CNT_W   = $clog2(N_WORDS);
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   chk_q, chk_d;
    logic [PAD-1:0]     shadow_q, shadow_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               bad_q, bad_d;
    logic               done_q, done_d;
    logic [TOTAL-1:0]   mux_q, mux_d;
    logic [SEL_W-1:0]   field;
    logic               field_bad;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            chk_q     <= '0;
            shadow_q  <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
            mux_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            shadow_q  <= shadow_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            bad_q     <= bad_d;
            done_q    <= done_d;
            mux_q     <= mux_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        shadow_d  = shadow_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        bad_d     = bad_q;
        done_d    = 1'b0;
        mux_d     = mux_q;
        field     = shadow_q[chk_q*SEL_W +: SEL_W];
        field_bad = 32'(field) >= N_IN;

        unique case (state_q)
            StIdle: begin
                if (bus.io_start) begin
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    bad_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (bus.io_abort) begin
                    state_d = StIdle;
                end else if (bus.io_cfg_valid) begin
                    // Padding bits above TOTAL land in the shadow but are never checked or committed.
                    shadow_d[cnt_q*CFG_W +: CFG_W] = bus.io_cfg_data;
                    if (cnt_q == CNT_W'(N_WORDS - 1)) begin
                        chk_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (bus.io_abort) begin
                    state_d = StIdle;
                end else begin
                    if (field_bad && !bad_q) begin
                        bad_d     = 1'b1;
                        err_idx_d = chk_q;
                    end
                    if (chk_q == IDX_W'(N_OUT - 1)) begin
                        // done_q is registered, so it pulses in the COMMIT cycle or the cycle after a reject.
                        done_d = 1'b1;
                        if (bad_q || field_bad) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StCommit;
                        end
                    end else begin
                        chk_d = chk_q + 1'b1;
                    end
                end
            end
            StCommit: begin
                mux_d   = shadow_q[TOTAL-1:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.io_cfg_ready   = (state_q == StLoad);
    assign bus.io_busy        = (state_q != StIdle);
    assign bus.io_done        = done_q;
    assign bus.io_err         = err_q;
    assign bus.io_err_idx     = err_idx_q;
    assign bus.io_mux_configs = mux_q;

`ifdef XBAR_CFG_READBACK_EN
    logic [PAD-1:0] mux_pad;

    always_comb begin
        mux_pad            = '0;
        mux_pad[TOTAL-1:0] = mux_q;
        bus.io_rd_data     = '0;
        if (32'(bus.io_rd_idx) < N_WORDS) begin
            bus.io_rd_data = mux_pad[bus.io_rd_idx*CFG_W +: CFG_W];
        end
    end
`endif
endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Self-checking bench for xbar_cfg_loader: table-driven loads with a done-pulse scoreboard,
// plus abort and mid-check reset sequences.
module tb_xbar_cfg_loader;
    localparam int unsigned N_IN    = 27;
    localparam int unsigned N_OUT   = 36;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned CFG_W   = 32;
    localparam int unsigned TOTAL   = 180;
    localparam int unsigned N_WORDS = 6;
    localparam int unsigned PAD     = 192;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    xbar_cfg_loader_if #(.CFG_W(CFG_W), .TOTAL(TOTAL)) bus ();

    xbar_cfg_loader #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .SEL_W(SEL_W),
        .CFG_W(CFG_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [TOTAL-1:0] mux;
        bit               err;
        int               idx;
    } exp_t;

    typedef struct {
        int mode;
        int b0_i;
        int b0_v;
        int b1_i;
        int b1_v;
        bit gaps;
        bit exp_err;
        int exp_idx;
        int exp_f30;
    } vec_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               last_acc = 0;
    int               done_cnt = 0;
    bit               pend = 1'b0;
    logic [TOTAL-1:0] pend_mux;
    logic [TOTAL-1:0] model_mux = '0;
    int               f[N_OUT];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: runs on the falling edge, away from the DUT's active edge.
    task automatic sample();
        exp_t e;
        cyc++;
        if (!reset) begin
            pend = 1'b0;
            return;
        end
        if (pend) begin
            chk("mux_after_done", bus.io_mux_configs, pend_mux);
            pend = 1'b0;
        end
        if (bus.io_cfg_valid && bus.io_cfg_ready && !bus.io_abort) last_acc = cyc;
        if (bus.io_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = sb.pop_front();
                chk("done_err", bus.io_err, e.err);
                if (e.err) chk("done_err_idx", bus.io_err_idx, e.idx);
                chk("done_latency", cyc - last_acc, 37);
                pend     = 1'b1;
                pend_mux = e.mux;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < N_OUT; i++) begin
            case (v.mode)
                0:       f[i] = i % 27;
                1:       f[i] = (i * 5) % 27;
                default: f[i] = 26;
            endcase
        end
        if (v.b0_i >= 0) f[v.b0_i] = v.b0_v;
        if (v.b1_i >= 0) f[v.b1_i] = v.b1_v;
    endtask

    function automatic logic [PAD-1:0] pack_img();
        logic [PAD-1:0] img;
        img = '0;
        for (int i = 0; i < N_OUT; i++) img[i*SEL_W +: SEL_W] = 5'(f[i]);
        img[PAD-1:TOTAL] = '1;
        return img;
    endfunction

    task automatic push_exp();
        exp_t           e;
        logic [PAD-1:0] img;
        int             first;
        first = -1;
        img   = pack_img();
        for (int i = 0; i < N_OUT; i++) begin
            if (f[i] >= int'(N_IN) && first < 0) first = i;
        end
        e.err = (first >= 0);
        e.idx = (first < 0) ? 0 : first;
        if (!e.err) model_mux = img[TOTAL-1:0];
        e.mux = model_mux;
        sb.push_back(e);
    endtask

    task automatic send_load(input bit gaps, input bit start_abort);
        logic [PAD-1:0] img;
        img = pack_img();
        bus.io_start = 1'b1;
        bus.io_abort = start_abort;
        tick();
        bus.io_start = 1'b0;
        bus.io_abort = 1'b0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin
                    bus.io_cfg_valid = 1'b0;
                    bus.io_start     = 1'($urandom_range(0, 1));
                    bus.io_cfg_data  = $urandom;
                    tick();
                end
                bus.io_start = 1'b0;
            end
            bus.io_cfg_data  = img[w*CFG_W +: CFG_W];
            bus.io_cfg_valid = 1'b1;
            tick();
        end
        bus.io_cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || pend) && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, (n < 100), 1);
        sb.delete();
        pend = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           vecs[7];
        logic [PAD-1:0] img;
        int             d0;

        //          mode b0_i b0_v b1_i b1_v gaps  err  idx f30
        vecs[0] = '{0, -1, 0, -1, 0, 1'b0, 1'b0, 0, 3};
        vecs[1] = '{0, 7, 31, 20, 27, 1'b0, 1'b1, 7, 3};
        vecs[2] = '{1, -1, 0, -1, 0, 1'b1, 1'b0, 0, 15};
        vecs[3] = '{1, 35, 27, -1, 0, 1'b0, 1'b1, 35, 15};
        vecs[4] = '{2, -1, 0, -1, 0, 1'b1, 1'b0, 0, 26};
        vecs[5] = '{2, 0, 27, 1, 31, 1'b0, 1'b1, 0, 26};
        vecs[6] = '{0, -1, 0, -1, 0, 1'b1, 1'b0, 0, 3};

        bus.io_start     = 1'b0;
        bus.io_abort     = 1'b0;
        bus.io_cfg_data  = '0;
        bus.io_cfg_valid = 1'b0;
`ifdef XBAR_CFG_READBACK_EN
        bus.io_rd_idx    = '0;
`endif
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_mux", bus.io_mux_configs, 0);
        chk("rst_ready", bus.io_cfg_ready, 0);
        chk("rst_busy", bus.io_busy, 0);
        chk("rst_err", bus.io_err, 0);
        chk("rst_done", bus.io_done, 0);
        chk("rst_err_idx", bus.io_err_idx, 0);

        for (int k = 0; k < 7; k++) begin
            build(vecs[k]);
            push_exp();
            send_load(vecs[k].gaps, 1'b0);
            wait_done($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_err", k), bus.io_err, vecs[k].exp_err);
            if (vecs[k].exp_err) chk($sformatf("vec%0d_err_idx", k), bus.io_err_idx, vecs[k].exp_idx);
            chk($sformatf("vec%0d_f30", k), bus.io_mux_configs[30*SEL_W +: SEL_W], vecs[k].exp_f30);
            chk($sformatf("vec%0d_busy", k), bus.io_busy, 0);
`ifdef XBAR_CFG_READBACK_EN
            if (k == 0) begin
                bus.io_rd_idx = 3'd5;
                #1;
                chk("rd5_hi", bus.io_rd_data[31:20], 0);
                chk("rd5_lo", bus.io_rd_data[19:0], model_mux[179:160]);
                bus.io_rd_idx = 3'd2;
                #1;
                chk("rd2", bus.io_rd_data, model_mux[95:64]);
                bus.io_rd_idx = 3'd6;
                #1;
                chk("rd6", bus.io_rd_data, 0);
                bus.io_rd_idx = 3'd0;
            end
`endif
        end

        // Abort with a word offered in the same cycle: no accept, no done, config untouched.
        build(vecs[2]);
        img = pack_img();
        bus.io_start = 1'b1;
        tick();
        bus.io_start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            bus.io_cfg_data  = img[w*CFG_W +: CFG_W];
            bus.io_cfg_valid = 1'b1;
            tick();
        end
        bus.io_cfg_data  = img[3*CFG_W +: CFG_W];
        bus.io_cfg_valid = 1'b1;
        bus.io_abort     = 1'b1;
        tick();
        bus.io_abort     = 1'b0;
        bus.io_cfg_valid = 1'b0;
        chk("abort_busy", bus.io_busy, 0);
        chk("abort_ready", bus.io_cfg_ready, 0);
        d0 = done_cnt;
        repeat (45) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_mux_kept", bus.io_mux_configs, model_mux);

        // Fresh load whose start cycle also carries abort: start must win.
        push_exp();
        send_load(1'b0, 1'b1);
        wait_done("after_abort");
        chk("after_abort_f30", bus.io_mux_configs[30*SEL_W +: SEL_W], 15);
        chk("after_abort_err", bus.io_err, 0);

        // Reset in the middle of CHECK.
        build(vecs[0]);
        send_load(1'b0, 1'b0);
        repeat (10) tick();
        chk("midchk_busy_pre", bus.io_busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_mux = '0;
        chk("midchk_mux", bus.io_mux_configs, 0);
        chk("midchk_busy", bus.io_busy, 0);
        chk("midchk_ready", bus.io_cfg_ready, 0);
        chk("midchk_err", bus.io_err, 0);
        d0 = done_cnt;
        repeat (45) tick();
        chk("midchk_no_done", done_cnt, d0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
